// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared constants, stroke record and capture states for the digit canvas writer
// Contents: canvas geometry (COLS x ROWS), coordinate widths, error result code,
//           stroke_t {sx, sy, ex, ey} and the capture state enum.
package digit_pkg;

   localparam int         COLS       = 12;
   localparam int         ROWS       = 8;
   localparam int         X_W        = 4;
   localparam int         Y_W        = 3;
   localparam logic [3:0] RESULT_ERR = 4'hF;

   typedef struct packed {
      logic [X_W-1:0] sx;
      logic [Y_W-1:0] sy;
      logic [X_W-1:0] ex;
      logic [Y_W-1:0] ey;
   } stroke_t;

   typedef enum logic [2:0] {
      IDLE,
      STROKE0,
      GAP,
      STROKE1,
      PRESENT,
      DONE
   } cap_state_t;

endpackage

// File: rtl/stroke_tracker.sv
// rtl/stroke_tracker.sv - start/end point register for one pen stroke
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_clear            zero the stroke (highest priority)
//   i_load             start a stroke: start = end = (i_x, i_y)
//   i_update           move the end point to (i_x, i_y)
//   i_x, i_y           pixel coordinate
//   o_stroke           {sx, sy, ex, ey}
module stroke_tracker
   import digit_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_load,
   input  logic                     i_update,
   input  logic [X_W-1:0]           i_x,
   input  logic [Y_W-1:0]           i_y,
   output logic [$bits(stroke_t)-1:0] o_stroke
);

   stroke_t r_stroke;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stroke <= '0;
      end else if (i_clear) begin
         r_stroke <= '0;
      end else if (i_load) begin
         r_stroke.sx <= i_x;
         r_stroke.sy <= i_y;
         r_stroke.ex <= i_x;
         r_stroke.ey <= i_y;
      end else if (i_update) begin
         r_stroke.ex <= i_x;
         r_stroke.ey <= i_y;
      end
   end

   assign o_stroke = r_stroke;

endmodule

// File: rtl/digit_canvas_writer.sv
// rtl/digit_canvas_writer.sv - turns pen samples into a 12x8 bitmap plus stroke endpoints and hands them to the recognizer
// Build option: define REC_WATCHDOG_EN to give up on the recognizer after
//               REC_TIMEOUT cycles in PRESENT (result 4'hF, recognizer reset pulse).
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_pen_valid/down/x/y         pen sample; accepted when down and x <= 11
//   i_clear                      abandon/finish capture, restart in IDLE
//   i_rec_ready, i_rec_result    recognizer handshake and digit
//   o_bitmap                     column k at [8k+7:8k], bit y = pixel (k,y)
//   o_stroke0, o_stroke1         {sx, sy, ex, ey}; stroke1 all-zero = none
//   o_new_x, o_new_y             last accepted pixel
//   o_read_data_valid            capture frozen, recognizer may read
//   o_rec_rst_n                  active-low recognizer reset
//   o_result, o_result_valid     latched digit and its one-cycle update pulse
module digit_canvas_writer
   import digit_pkg::*;
#(
   parameter int GAP_TIMEOUT = 1000,
   parameter int REC_TIMEOUT = 4096
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pen_valid,
   input  logic        i_pen_down,
   input  logic [3:0]  i_pen_x,
   input  logic [2:0]  i_pen_y,
   input  logic        i_clear,
   input  logic        i_rec_ready,
   input  logic [3:0]  i_rec_result,
   output logic [95:0] o_bitmap,
   output logic [13:0] o_stroke0,
   output logic [13:0] o_stroke1,
   output logic [3:0]  o_new_x,
   output logic [2:0]  o_new_y,
   output logic        o_read_data_valid,
   output logic        o_rec_rst_n,
   output logic [3:0]  o_result,
   output logic        o_result_valid
);

   // One counter serves both the pen-up gap and the recognizer watchdog;
   // they are never active at the same time.
   localparam int CNT_MAX = (GAP_TIMEOUT > REC_TIMEOUT) ? GAP_TIMEOUT : REC_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   cap_state_t              r_state;
   cap_state_t              w_next_state;
   logic [COLS*ROWS-1:0]    r_bitmap;
   logic [X_W-1:0]          r_new_x;
   logic [Y_W-1:0]          r_new_y;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_rec_rst_n;
   logic [3:0]              r_result;
   logic                    r_result_valid;

   logic                    w_accept;
   logic                    w_pen_up;
   logic                    w_gap_limit;
   logic [6:0]              w_bit_idx;
   logic                    w_write;
   logic                    w_load0;
   logic                    w_upd0;
   logic                    w_load1;
   logic                    w_upd1;
   logic                    w_cnt_clr;
   logic                    w_cnt_inc;
   logic                    w_res_load;
   logic [3:0]              w_res_val;
   logic                    w_rec_pulse;
`ifdef REC_WATCHDOG_EN
   logic                    w_rec_limit;
   assign w_rec_limit = (r_cnt == CNT_W'(REC_TIMEOUT - 1));
`endif

   assign w_accept    = i_pen_valid & i_pen_down & (i_pen_x <= 4'(COLS - 1));
   assign w_pen_up    = i_pen_valid & ~i_pen_down;
   assign w_gap_limit = (r_cnt == CNT_W'(GAP_TIMEOUT - 1));
   // ROWS is 8, so pixel (x,y) sits at bit 8x+y = {x,y}.
   assign w_bit_idx   = {i_pen_x, i_pen_y};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_write      = 1'b0;
      w_load0      = 1'b0;
      w_upd0       = 1'b0;
      w_load1      = 1'b0;
      w_upd1       = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_res_load   = 1'b0;
      w_res_val    = i_rec_result;
      w_rec_pulse  = 1'b0;
      // Clear overrides everything, including a coincident recognizer result.
      if (i_clear) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_write      = 1'b1;
                  w_load0      = 1'b1;
                  w_next_state = STROKE0;
               end
            end
            STROKE0: begin
               if (w_accept) begin
                  w_write = 1'b1;
                  w_upd0  = 1'b1;
               end else if (w_pen_up) begin
                  w_cnt_clr    = 1'b1;
                  w_next_state = GAP;
               end
            end
            GAP: begin
               // A sample on the limit cycle still opens stroke 1.
               if (w_accept) begin
                  w_write      = 1'b1;
                  w_load1      = 1'b1;
                  w_next_state = STROKE1;
               end else if (w_gap_limit) begin
                  w_cnt_clr    = 1'b1;
                  w_next_state = PRESENT;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
            STROKE1: begin
               if (w_accept) begin
                  w_write = 1'b1;
                  w_upd1  = 1'b1;
               end else if (w_pen_up) begin
                  w_cnt_clr    = 1'b1;
                  w_next_state = PRESENT;
               end
            end
            PRESENT: begin
               if (i_rec_ready) begin
                  w_res_load   = 1'b1;
                  w_next_state = DONE;
`ifdef REC_WATCHDOG_EN
               end else if (w_rec_limit) begin
                  w_res_load   = 1'b1;
                  w_res_val    = RESULT_ERR;
                  w_rec_pulse  = 1'b1;
                  w_next_state = DONE;
               end else begin
                  w_cnt_inc = 1'b1;
`endif
               end
            end
            DONE: begin
               w_next_state = DONE;
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear || w_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bitmap <= '0;
         r_new_x  <= '0;
         r_new_y  <= '0;
      end else if (i_clear) begin
         r_bitmap <= '0;
         r_new_x  <= '0;
         r_new_y  <= '0;
      end else if (w_write) begin
         r_bitmap[w_bit_idx] <= 1'b1;
         r_new_x             <= i_pen_x;
         r_new_y             <= i_pen_y;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rec_rst_n    <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_rec_rst_n    <= ~(i_clear | w_rec_pulse);
         r_result_valid <= w_res_load;
         if (w_res_load) begin
            r_result <= w_res_val;
         end
      end
   end

   stroke_tracker u_stroke0 (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (i_clear),
      .i_load   (w_load0),
      .i_update (w_upd0),
      .i_x      (i_pen_x),
      .i_y      (i_pen_y),
      .o_stroke (o_stroke0)
   );

   stroke_tracker u_stroke1 (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (i_clear),
      .i_load   (w_load1),
      .i_update (w_upd1),
      .i_x      (i_pen_x),
      .i_y      (i_pen_y),
      .o_stroke (o_stroke1)
   );

   assign o_bitmap          = r_bitmap;
   assign o_new_x           = r_new_x;
   assign o_new_y           = r_new_y;
   assign o_read_data_valid = (r_state == PRESENT);
   assign o_rec_rst_n       = r_rec_rst_n;
   assign o_result          = r_result;
   assign o_result_valid    = r_result_valid;

endmodule

// File: tb/tb_digit_canvas_writer.sv
// tb/tb_digit_canvas_writer.sv - randomized self-checking bench for digit_canvas_writer
module tb_digit_canvas_writer;

   localparam int G  = 20;
   localparam int RT = 16;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_pen_valid, i_pen_down, i_clear, i_rec_ready;
   logic [3:0]  i_pen_x, i_rec_result;
   logic [2:0]  i_pen_y;
   logic [95:0] o_bitmap;
   logic [13:0] o_stroke0, o_stroke1;
   logic [3:0]  o_new_x, o_result;
   logic [2:0]  o_new_y;
   logic        o_read_data_valid, o_rec_rst_n, o_result_valid;

   digit_canvas_writer #(.GAP_TIMEOUT(G), .REC_TIMEOUT(RT)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_pen_valid(i_pen_valid), .i_pen_down(i_pen_down),
      .i_pen_x(i_pen_x), .i_pen_y(i_pen_y),
      .i_clear(i_clear), .i_rec_ready(i_rec_ready), .i_rec_result(i_rec_result),
      .o_bitmap(o_bitmap), .o_stroke0(o_stroke0), .o_stroke1(o_stroke1),
      .o_new_x(o_new_x), .o_new_y(o_new_y),
      .o_read_data_valid(o_read_data_valid), .o_rec_rst_n(o_rec_rst_n),
      .o_result(o_result), .o_result_valid(o_result_valid)
   );

   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   typedef struct { bit v; bit d; int x; int y; } samp_t;
   samp_t seq[$];

   int          n_vec = 0;
   int          n_bad = 0;
   logic [3:0]  exp_result = 4'h0;
   logic [95:0] exp_bm;
   logic [13:0] exp_s0, exp_s1;
   int          exp_nx, exp_ny, exp_p;
   int          t_present;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic bit acc(samp_t s);
      return s.v && s.d && (s.x <= 11);
   endfunction

   function automatic bit up(samp_t s);
      return s.v && !s.d;
   endfunction

   function automatic logic [13:0] pk(int sx, int sy, int ex, int ey);
      return {4'(sx), 3'(sy), 4'(ex), 3'(ey)};
   endfunction

   task automatic push(bit v, bit d, int x, int y);
      samp_t s;
      s.v = v; s.d = d; s.x = x; s.y = y;
      seq.push_back(s);
   endtask

   // Cycles that must not register as pen activity in IDLE or GAP.
   task automatic push_junk(int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0: push(0, 0, 0, 0);
            1: push(1, 0, $urandom_range(0, 15), $urandom_range(0, 7));
            default: push(1, 1, $urandom_range(12, 15), $urandom_range(0, 7));
         endcase
      end
   endtask

   task automatic gen_stroke(int n);
      push(1, 1, $urandom_range(0, 11), $urandom_range(0, 7));
      for (int i = 1; i < n; i++) begin
         case ($urandom_range(0, 7))
            0: push(1, 1, $urandom_range(12, 15), $urandom_range(0, 7));
            1: push(0, 1, 0, 0);
            default: push(1, 1, $urandom_range(0, 11), $urandom_range(0, 7));
         endcase
      end
      push(1, 0, $urandom_range(0, 15), $urandom_range(0, 7));
   endtask

   // Paints accepted samples in [a,b) into exp_bm and returns the stroke record.
   task automatic paint(int a, int b, output logic [13:0] st);
      int last;
      last = a;
      for (int k = a; k < b; k++) begin
         if (acc(seq[k])) begin
            exp_bm[seq[k].x * 8 + seq[k].y] = 1'b1;
            last = k;
         end
      end
      st = pk(seq[a].x, seq[a].y, seq[last].x, seq[last].y);
      exp_nx = seq[last].x;
      exp_ny = seq[last].y;
   endtask

   // Stroke 0 runs from the first accepted sample to the next pen-up; stroke 1
   // counts only if its first accepted sample comes fewer than G idle cycles later.
   task automatic model();
      int i0, u0, i1, u1;
      i0 = -1; u0 = -1; i1 = -1; u1 = -1;
      exp_bm = '0; exp_s0 = '0; exp_s1 = '0;
      for (int k = 0; k < seq.size(); k++) if (i0 < 0 && acc(seq[k])) i0 = k;
      for (int k = i0 + 1; k < seq.size(); k++) if (u0 < 0 && up(seq[k])) u0 = k;
      for (int k = u0 + 1; k < seq.size(); k++) if (i1 < 0 && acc(seq[k])) i1 = k;
      paint(i0, u0, exp_s0);
      if (i1 >= 0 && (i1 - u0 - 1) < G) begin
         for (int k = i1 + 1; k < seq.size(); k++) if (u1 < 0 && up(seq[k])) u1 = k;
         paint(i1, u1, exp_s1);
         exp_p = u1;
      end else begin
         exp_p = u0 + G;
      end
   endtask

   task automatic drive(samp_t s);
      i_pen_valid = s.v;
      i_pen_down  = s.d;
      i_pen_x     = 4'(s.x);
      i_pen_y     = 3'(s.y);
   endtask

   task automatic idle_inputs();
      i_pen_valid = 0; i_pen_down = 0; i_pen_x = 0; i_pen_y = 0;
   endtask

   task automatic run_capture();
      int first;
      samp_t z;
      z.v = 0; z.d = 0; z.x = 0; z.y = 0;
      model();
      while (seq.size() > exp_p + 3) void'(seq.pop_back());
      while (seq.size() < exp_p + 3) seq.push_back(z);
      first = -1;
      for (int k = 0; k < seq.size(); k++) begin
         @(negedge clk);
         if (o_read_data_valid && first < 0) begin
            first = k - 1;
            t_present = ncyc;
         end
         drive(seq[k]);
      end
      @(negedge clk);
      idle_inputs();
      check_eq("present_edge", 96'(first), 96'(exp_p));
      check_eq("bitmap", o_bitmap, exp_bm);
      check_eq("stroke0", 96'(o_stroke0), 96'(exp_s0));
      check_eq("stroke1", 96'(o_stroke1), 96'(exp_s1));
      check_eq("new_xy", 96'({o_new_x, o_new_y}), 96'({4'(exp_nx), 3'(exp_ny)}));
   endtask

   task automatic do_clear();
      i_clear = 1;
      @(negedge clk);
      i_clear = 0;
      check_eq("clr_rec_rst_low", 96'(o_rec_rst_n), 96'(0));
      check_eq("clr_bitmap", o_bitmap, 96'(0));
      check_eq("clr_strokes", 96'({o_stroke0, o_stroke1, o_new_x, o_new_y}), 96'(0));
      check_eq("clr_result_kept", 96'(o_result), 96'(exp_result));
      check_eq("clr_rdv", 96'(o_read_data_valid), 96'(0));
      @(negedge clk);
      check_eq("clr_rec_rst_high", 96'(o_rec_rst_n), 96'(1));
   endtask

   // mode 0: recognizer answers; mode 1: clear coincides with ready; mode 2: watchdog
   task automatic finish_capture(int mode);
      logic [3:0] r;
      int pulses, w;
`ifdef REC_WATCHDOG_EN
      w = $urandom_range(0, 5);
`else
      w = $urandom_range(0, 30);
`endif
      if (mode != 2) begin
         repeat (w) @(negedge clk);
         check_eq("present_holds", 96'({o_read_data_valid, o_result_valid}), 96'(2'b10));
      end
      r = 4'($urandom_range(0, 9));
      if (mode == 0) begin
         i_rec_ready = 1; i_rec_result = r;
         pulses = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
               check_eq("result", 96'(o_result), 96'(r));
               check_eq("done_rdv", 96'(o_read_data_valid), 96'(0));
            end
            if (i == 2) i_rec_ready = 0;
            if (o_result_valid) pulses++;
         end
         check_eq("result_pulses", 96'(pulses), 96'(1));
         exp_result = r;
         do_clear();
      end else if (mode == 1) begin
         i_rec_ready = 1; i_rec_result = ~exp_result; i_clear = 1;
         @(negedge clk);
         i_rec_ready = 0; i_clear = 0;
         check_eq("coinc_no_valid", 96'(o_result_valid), 96'(0));
         check_eq("coinc_result", 96'(o_result), 96'(exp_result));
         check_eq("coinc_rec_rst", 96'(o_rec_rst_n), 96'(0));
         check_eq("coinc_rdv", 96'(o_read_data_valid), 96'(0));
         @(negedge clk);
         check_eq("coinc_rec_rst_hi", 96'(o_rec_rst_n), 96'(1));
         check_eq("coinc_no_valid2", 96'(o_result_valid), 96'(0));
      end else begin
         pulses = 0;
         for (int i = 0; i < 4 * RT && !o_result_valid; i++) @(negedge clk);
         check_eq("wd_valid", 96'(o_result_valid), 96'(1));
         check_eq("wd_latency", 96'(ncyc - t_present), 96'(RT));
         check_eq("wd_result", 96'(o_result), 96'(4'hF));
         check_eq("wd_rec_rst", 96'(o_rec_rst_n), 96'(0));
         @(negedge clk);
         check_eq("wd_after", 96'({o_result_valid, o_rec_rst_n, o_read_data_valid}), 96'(3'b010));
         exp_result = 4'hF;
         do_clear();
      end
   endtask

   task automatic gen_random();
      int d;
      seq.delete();
      push_junk($urandom_range(0, 3));
      gen_stroke($urandom_range(1, 6));
      case ($urandom_range(0, 4))
         0: d = 0;
         1: d = $urandom_range(1, G - 2);
         2: d = G - 1;
         3: d = G;
         default: d = G + 2;
      endcase
      push_junk(d);
      gen_stroke($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) gen_stroke(2);
   endtask

   task automatic reset_mid_stroke1();
      seq.delete();
      push(1, 1, 1, 1); push(1, 1, 2, 1); push(1, 0, 0, 0);
      push(0, 0, 0, 0); push(0, 0, 0, 0);
      push(1, 1, 5, 5); push(1, 1, 6, 6);
      foreach (seq[k]) begin
         @(negedge clk);
         drive(seq[k]);
      end
      @(negedge clk);
      idle_inputs();
      check_eq("pre_rst_stroke1", 96'(o_stroke1), 96'(pk(5, 5, 6, 6)));
      #2 i_rst = 1;
      #1;
      check_eq("rst_outputs", 96'({o_bitmap[15:0], o_stroke0, o_stroke1, o_new_x, o_new_y, o_result}), 96'(0));
      check_eq("rst_ctrl", 96'({o_rec_rst_n, o_read_data_valid, o_result_valid}), 96'(0));
      @(negedge clk);
      i_rst = 0;
      #1 check_eq("rst_rel_low", 96'(o_rec_rst_n), 96'(0));
      @(negedge clk);
      check_eq("rst_rel_high", 96'({o_rec_rst_n, o_read_data_valid}), 96'(2'b10));
      exp_result = 4'h0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst = 1; i_clear = 0; i_rec_ready = 0; i_rec_result = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check_eq("reset_state", 96'({o_bitmap, o_rec_rst_n, o_read_data_valid, o_result_valid, o_result}), 96'(0));
      i_rst = 0;
      @(negedge clk);
      check_eq("reset_release", 96'(o_rec_rst_n), 96'(1));

      // Three diagonal points, single stroke.
      seq.delete();
      push(1, 1, 0, 0); push(1, 1, 1, 1); push(1, 1, 2, 2); push(1, 0, 0, 0);
      run_capture();
      check_eq("tp1_stroke0", 96'(o_stroke0), 96'(pk(0, 0, 2, 2)));
      check_eq("tp1_bits", o_bitmap, (96'(1) << 0) | (96'(1) << 9) | (96'(1) << 18));
      finish_capture(0);

      // Two strokes separated by 10 idle cycles.
      seq.delete();
      for (int x = 0; x <= 5; x++) push(1, 1, x, 0);
      push(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) push(0, 0, 0, 0);
      for (int x = 11; x >= 6; x--) push(1, 1, x, 7);
      push(1, 0, 0, 0);
      run_capture();
      check_eq("tp2_stroke1", 96'(o_stroke1), 96'(pk(11, 7, 6, 7)));
      finish_capture(1);

      // Off-canvas sample mid-stroke, then pen-up still closes.
      seq.delete();
      push(1, 1, 3, 3); push(1, 1, 12, 5); push(1, 0, 14, 2);
      run_capture();
      check_eq("tp3_stroke0", 96'(o_stroke0), 96'(pk(3, 3, 3, 3)));
      finish_capture(0);

      for (int it = 0; it < 24; it++) begin
         gen_random();
         run_capture();
`ifdef REC_WATCHDOG_EN
         finish_capture($urandom_range(0, 2));
`else
         finish_capture($urandom_range(0, 1));
`endif
         if (it == 10) reset_mid_stroke1();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
